pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, successor to the fixed-width MEM/WB-style latch.
- Carries a generic control bundle, data word and destination-register index between any two pipeline stages.
- Adds valid/ready flow control with a 2-entry skid buffer, synchronous flush (bubble insertion) and a saturating stall-cycle counter.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, so every stage boundary supports stall and flush uniformly.

Parameters:
- CTRL_W, 2: width of the control bundle (e.g. MemtoReg, RegWrite); all control bits are zeroed in bubbles.
- DATA_W, 32: width of the data payload.
- REG_W, 5: width of the destination register index.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous flush; drops all held and incoming entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data.
- in_reg  in  REG_W  upstream destination register.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts the entry this cycle.
- out_ctrl  out  CTRL_W  control bundle; forced to all-zero whenever out_valid=0.
- out_data  out  DATA_W  data.
- out_reg  out  REG_W  destination register.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, out_reg=0, in_ready=1, stall_cnt=0, skid entry invalid. reset overrides flush and all handshakes.
- Storage: main entry M (drives the out_* ports) plus skid entry S. in_ready is a registered output equal to !S.valid.
- Handshakes: accept when in_valid & in_ready; drain when out_valid & out_ready.
- States:
  - EMPTY: M invalid, S invalid.
  - ONE: M valid, S invalid.
  - TWO: M valid, S valid.
- Transitions (no flush):
  - EMPTY + accept -> ONE; M loads the input. Latency is 1 cycle: an input on edge n appears on out_* after edge n.
  - ONE + accept + drain -> ONE; M loads the input (full throughput).
  - ONE + accept, no drain -> TWO; S loads the input, M holds.
  - ONE + drain, no accept -> EMPTY.
  - TWO + drain -> ONE; M loads from S, S is invalidated. No accept is possible because in_ready=0.
  - TWO, no drain -> hold both entries.
- Ordering: entries leave strictly in acceptance order; no entry is duplicated or lost.
- Output hold: while out_valid=1 and out_ready=0, all out_* are stable.
- Flush: on the next edge, M and S are invalidated, out_ctrl=0 and in_ready=1. An input offered in the flush cycle is dropped. out_data and out_reg hold their prior values (don't-care, since out_valid=0).
- Flush vs. drain: flush and drain in the same cycle -> the drain is honoured downstream and the state still clears.
- Bubble rule: while out_valid=0, out_ctrl must read zero, so no RegWrite or MemWrite leaks from a bubble.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by reset.
- Reset mid-operation (state TWO): both entries are discarded and the block is in EMPTY on the next cycle.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

Test Plan:
- Streaming: reset, then in_valid=1 with data 0x11, 0x22, 0x33 on consecutive cycles and out_ready=1 -> out_data 0x11, 0x22, 0x33 one cycle later each; in_ready stays 1; stall_cnt=0.
- Backpressure: push 0xA, 0xB with out_ready=0 -> after the 2nd accept in_ready=0 and out_data holds 0xA. Hold 3 cycles -> stall_cnt=3. Raise out_ready -> 0xA then 0xB; in_ready returns to 1.
- Flush in TWO: with entries 0xA and 0xB held, assert flush alongside in_valid=1 data 0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xC is never output.
- Bubble control: in_ctrl=2'b11 accepted then drained with no new input -> once out_valid=0, out_ctrl=2'b00.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
- Reset mid-operation: in state TWO assert reset for 1 cycle with flush=1 -> out_valid=0, in_ready=1, stall_cnt=0, out_data=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready flow control, 2-entry skid,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_reg,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d, in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic [REG_W-1:0]  m_reg_q, m_reg_d, s_reg_q, s_reg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, drain, m_free;

    assign accept = in_valid & in_ready_q;
    assign drain  = m_valid_q & out_ready;
    // M can take a new entry when it is empty or its entry leaves this cycle
    assign m_free = !m_valid_q || drain;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        m_reg_d   = m_reg_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        s_reg_d   = s_reg_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_free) begin
            m_valid_d = s_valid_q || accept;
            m_ctrl_d  = s_valid_q ? s_ctrl_q : in_ctrl;
            m_data_d  = s_valid_q ? s_data_q : (accept ? in_data : m_data_q);
            m_reg_d   = s_valid_q ? s_reg_q : (accept ? in_reg : m_reg_q);
            s_valid_d = 1'b0;
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl;
            s_data_d  = in_data;
            s_reg_d   = in_reg;
        end
        // bubbles never carry control bits
        m_ctrl_d   = m_valid_d ? m_ctrl_d : '0;
        in_ready_d = !s_valid_d;
        cnt_d      = (m_valid_q && !out_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            m_ctrl_q   <= '0;
            m_data_q   <= '0;
            m_reg_q    <= '0;
            s_valid_q  <= 1'b0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
            s_reg_q    <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_ctrl_q   <= m_ctrl_d;
            m_data_q   <= m_data_d;
            m_reg_q    <= m_reg_d;
            s_valid_q  <= s_valid_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
            s_reg_q    <= s_reg_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid_q;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign out_reg   = m_reg_q;
    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of streaming, backpressure, flush, bubbles, saturation and reset.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_ctrl, out_ctrl;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_reg, out_reg;
    logic [3:0]  stall_cnt;
    int          total = 0;
    int          bad = 0;

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(32), .REG_W(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data), .in_reg(in_reg),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .out_reg(out_reg), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [31:0] d, input logic [4:0] r);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        in_reg   = r;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_data = '0; in_reg = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ctrl", out_ctrl, 0);

        in_valid = 1'b1; in_ctrl = 2'b01; in_data = 32'h11; in_reg = 5'd1;
        tick();
        chk("s1_valid", out_valid, 1);
        chk("s1_data", out_data, 32'h11);
        in_data = 32'h22; in_reg = 5'd2;
        tick();
        chk("s2_data", out_data, 32'h22);
        chk("s2_ready", in_ready, 1);
        in_data = 32'h33; in_reg = 5'd3;
        tick();
        chk("s3_data", out_data, 32'h33);
        chk("s3_reg", out_reg, 3);
        in_valid = 1'b0;
        tick();
        chk("s_end_valid", out_valid, 0);
        chk("s_end_ctrl", out_ctrl, 0);
        chk("s_cnt", stall_cnt, 0);

        out_ready = 1'b0;
        push(2'b10, 32'hA, 5'd10);
        chk("bp1_data", out_data, 32'hA);
        chk("bp1_ready", in_ready, 1);
        chk("bp1_cnt", stall_cnt, 0);
        push(2'b01, 32'hB, 5'd11);
        chk("bp2_ready", in_ready, 0);
        chk("bp2_data", out_data, 32'hA);
        chk("bp2_ctrl", out_ctrl, 2'b10);
        chk("bp2_cnt", stall_cnt, 1);
        tick(); tick();
        chk("bp_hold_cnt", stall_cnt, 3);
        chk("bp_hold_data", out_data, 32'hA);
        chk("bp_hold_reg", out_reg, 10);
        out_ready = 1'b1;
        tick();
        chk("bp_drain_data", out_data, 32'hB);
        chk("bp_drain_reg", out_reg, 11);
        chk("bp_drain_ctrl", out_ctrl, 2'b01);
        chk("bp_drain_ready", in_ready, 1);
        chk("bp_drain_cnt", stall_cnt, 3);
        tick();
        chk("bp_empty_valid", out_valid, 0);

        push(2'b11, 32'h5, 5'd5);
        chk("bub_ctrl_on", out_ctrl, 2'b11);
        tick();
        chk("bub_valid", out_valid, 0);
        chk("bub_ctrl_off", out_ctrl, 0);

        out_ready = 1'b0;
        push(2'b11, 32'hA, 5'd10);
        push(2'b11, 32'hB, 5'd11);
        chk("fl_two_ready", in_ready, 0);
        chk("fl_two_cnt", stall_cnt, 4);
        flush = 1'b1;
        push(2'b11, 32'hC, 5'd12);
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("fl_no_c", out_valid, 0);
        chk("fl_cnt", stall_cnt, 5);

        out_ready = 1'b0;
        push(2'b01, 32'h7, 5'd7);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", stall_cnt, 15);
        tick();
        chk("sat_hold", stall_cnt, 15);
        chk("sat_data", out_data, 32'h7);

        push(2'b01, 32'h8, 5'd8);
        chk("rm_two_ready", in_ready, 0);
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        chk("rm_valid", out_valid, 0);
        chk("rm_ready", in_ready, 1);
        chk("rm_cnt", stall_cnt, 0);
        chk("rm_data", out_data, 0);
        chk("rm_reg", out_reg, 0);
        out_ready = 1'b1;
        tick();
        chk("rm_empty", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
